mmt_sync_tx: RTL and testbench
==============================

MMT_SYNC_TX -- requirements
Module: mmt_sync_tx

Interface
REQ-001 SHALL have parameter Width, default 8, meaning data bits carried per transfer.
REQ-002 SHALL have parameter Depth, default 3, meaning flop stages in the internal ack synchronizer; legal range 2..4.
REQ-003 SHALL have parameter TransportCycle, default 2, meaning cycles data_out is held stable before req_out toggles; legal range 0..15.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, meaning the ack wait limit; used only when MMT_SYNC_TX_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic is on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port src_valid, input, 1, source offers src_data.
REQ-008 SHALL have port src_data, input, Width, payload.
REQ-009 SHALL have port src_ready, output, 1, block accepts a payload this cycle.
REQ-010 SHALL have port req_out, output, 1, toggle request to the destination domain; driven directly from a flop.
REQ-011 SHALL have port data_out, output, Width, captured payload; driven directly from flops.
REQ-012 SHALL have port ack_async, input, 1, raw toggle ack from the destination domain.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a transfer completes.
REQ-014 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL synchronize ack_async through Depth flops to ack_sync; no other logic before the first flop.
REQ-016 SHALL implement states IDLE, SETUP, WAIT_ACK and ERROR; src_ready = (state==IDLE).
REQ-017 SHALL define accept as src_valid && src_ready at edge N; at N, data_out <= src_data and the hold counter <= TransportCycle.
REQ-018 SHALL, with TransportCycle=0, toggle req_out at edge N and enter WAIT_ACK directly.
REQ-019 SHALL, with TransportCycle>=1, enter SETUP at N and decrement the counter each edge, toggling req_out and entering WAIT_ACK at edge N+TransportCycle.
REQ-020 SHALL hold data_out and req_out constant outside the accept and toggle edges.
REQ-021 SHALL, in WAIT_ACK at the edge where ack_sync==req_out, enter IDLE and assert done for exactly the following cycle.
REQ-022 SHALL ignore src_valid outside IDLE; src_data is neither captured nor dropped silently, because src_ready is low.
REQ-023 SHALL ignore ack_sync changes in IDLE and SETUP.
REQ-024 SHALL allow back-to-back transfers: a new accept is legal in the same cycle that done is high.

Reset
REQ-025 SHALL, when rst is high at an edge, set state=IDLE, req_out=0, data_out=0, done=0, err=0, hold counter=0, timeout counter=0, and all ack_sync flops=0, regardless of state.
REQ-026 SHALL assert src_ready in the first cycle after rst deasserts; the destination side is reset concurrently at system level.

Configuration
REQ-027 SHALL, with MMT_SYNC_TX_TIMEOUT_EN defined, count cycles in WAIT_ACK; after TimeoutCycles cycles without a match, set err=1 and enter ERROR.
REQ-028 SHALL, in ERROR, keep src_ready=0, err=1, and req_out and data_out unchanged; only rst exits ERROR.
REQ-029 SHALL, without MMT_SYNC_TX_TIMEOUT_EN, tie err to 0, have no timeout counter and no ERROR state, and wait in WAIT_ACK indefinitely.

Verification
REQ-030 SHALL cover a single transfer: defaults, accept 0xA5 at cycle 10 -> data_out=0xA5 at 10, req_out 0->1 at 12; ack_async toggled at 20 -> done high at cycle 24, src_ready high from 24.
REQ-031 SHALL cover TransportCycle=0: accept 0x3C -> req_out toggles on the accept edge, with data_out=0x3C on the same edge.
REQ-032 SHALL cover busy hold-off: src_valid held with changing data during SETUP and WAIT_ACK -> src_ready=0 and data_out unchanged; the next payload is accepted only in the done cycle or later.
REQ-033 SHALL cover reset mid-operation: rst pulsed in WAIT_ACK with req_out=1 -> next cycle req_out=0, data_out=0, src_ready=1, done=0.
REQ-034 SHALL cover timeout with the macro defined: TimeoutCycles=16, no ack -> err=1 after 16 WAIT_ACK cycles, src_ready stays 0 until rst; without the macro, err stays 0 over the same stimulus.
REQ-035 SHALL cover a spurious ack: ack_async toggled while IDLE -> no done and no state change, and the next transfer completes on a correctly matched ack.

Source files
------------

// File: rtl/mmt_sync_tx.sv
// Toggle-handshake transmitter: captures a payload, holds it for TransportCycle
// cycles, toggles req_out and waits for the synchronised ack. Optional timeout: MMT_SYNC_TX_TIMEOUT_EN.
module mmt_sync_tx #(
    parameter int Width          = 8,
    parameter int Depth          = 3,
    parameter int TransportCycle = 2,
    parameter int TimeoutCycles  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [Width-1:0] src_data,
    output logic             src_ready,
    output logic             req_out,
    output logic [Width-1:0] data_out,
    input  logic             ack_async,
    output logic             done,
    output logic             err
);

    if (Depth < 2 || Depth > 4 || TransportCycle < 0 || TransportCycle > 15 || TimeoutCycles < 1)
    begin : g_bad_param
        $error("mmt_sync_tx: parameter out of legal range");
    end

`ifdef MMT_SYNC_TX_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, ERROR} state_t;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TimeoutCycles - 1);
`else
    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;
`endif

    localparam logic [3:0] HOLD_INIT = 4'(TransportCycle);

    state_t           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic             req_d;
    logic [Width-1:0] data_d;
    logic             done_q, done_d;
    logic [Depth-1:0] sync_q;
    logic             ack_sync;

`ifdef MMT_SYNC_TX_TIMEOUT_EN
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             err_q, err_d;
`endif

    // ack_async feeds the first flop directly; the last flop is the usable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Depth-2:0], ack_async};
        end
    end

    assign ack_sync  = sync_q[Depth-1];
    assign src_ready = (state_q == IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        req_d   = req_out;
        data_d  = data_out;
        done_d  = 1'b0;
`ifdef MMT_SYNC_TX_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (src_valid) begin
                    data_d = src_data;
                    hold_d = HOLD_INIT;
`ifdef MMT_SYNC_TX_TIMEOUT_EN
                    tcnt_d = '0;
`endif
                    if (TransportCycle == 0) begin
                        req_d   = ~req_out;
                        state_d = WAIT_ACK;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                // Toggle on the edge where the counter would reach zero.
                if (hold_q <= 4'd1) begin
                    req_d   = ~req_out;
                    hold_d  = '0;
                    state_d = WAIT_ACK;
`ifdef MMT_SYNC_TX_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_out) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`ifdef MMT_SYNC_TX_TIMEOUT_EN
                else if (tcnt_q == TMAX) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
`ifdef MMT_SYNC_TX_TIMEOUT_EN
            ERROR: begin
                err_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            req_out  <= 1'b0;
            data_out <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            req_out  <= req_d;
            data_out <= data_d;
            done_q   <= done_d;
        end
    end

`ifdef MMT_SYNC_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mmt_sync_tx.sv
// Scoreboard bench for mmt_sync_tx: instance A uses defaults (TransportCycle=2),
// instance B uses TransportCycle=0 and TimeoutCycles=16.
module tb_mmt_sync_tx;

`ifdef MMT_SYNC_TX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } tx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_q = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       a_valid = 1'b0, a_ready, a_req, a_ack = 1'b0, a_done, a_err;
    logic [7:0] a_data = '0, a_dout;
    logic       b_valid = 1'b0, b_ready, b_req, b_ack = 1'b0, b_done, b_err;
    logic [7:0] b_data = '0, b_dout;

    tx_t a_txq[$], b_txq[$];
    int  a_dq[$], b_dq[$];
    tx_t a_e, b_e;
    int  a_dc, b_dc;
    logic a_req_prev = 1'b0, a_done_prev = 1'b0;
    logic b_req_prev = 1'b0, b_done_prev = 1'b0;

    mmt_sync_tx #(.Width(8), .Depth(3), .TransportCycle(2), .TimeoutCycles(1024)) u_dut_a (
        .clk(clk), .rst(rst), .src_valid(a_valid), .src_data(a_data), .src_ready(a_ready),
        .req_out(a_req), .data_out(a_dout), .ack_async(a_ack), .done(a_done), .err(a_err)
    );

    mmt_sync_tx #(.Width(8), .Depth(3), .TransportCycle(0), .TimeoutCycles(16)) u_dut_b (
        .clk(clk), .rst(rst), .src_valid(b_valid), .src_data(b_data), .src_ready(b_ready),
        .req_out(b_req), .data_out(b_dout), .ack_async(b_ack), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d: got an event, required none", name, cyc);
    endtask

    // Monitors: every req_out toggle and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_q === 1'b0) begin
            if (a_req !== a_req_prev) begin
                if (a_txq.size() == 0) unexpected("a_req_toggle");
                else begin
                    a_e = a_txq.pop_front();
                    chk("a_req_cycle", cyc, a_e.cyc);
                    chk("a_req_data", a_dout, a_e.data);
                end
            end
            if (a_done === 1'b1) begin
                if (a_done_prev === 1'b1) unexpected("a_done_width");
                if (a_dq.size() == 0) unexpected("a_done");
                else begin
                    a_dc = a_dq.pop_front();
                    chk("a_done_cycle", cyc, a_dc);
                end
            end
        end
        a_req_prev  <= a_req;
        a_done_prev <= a_done;
    end

    always @(negedge clk) begin
        if (rst_q === 1'b0) begin
            if (b_req !== b_req_prev) begin
                if (b_txq.size() == 0) unexpected("b_req_toggle");
                else begin
                    b_e = b_txq.pop_front();
                    chk("b_req_cycle", cyc, b_e.cyc);
                    chk("b_req_data", b_dout, b_e.data);
                end
            end
            if (b_done === 1'b1) begin
                if (b_done_prev === 1'b1) unexpected("b_done_width");
                if (b_dq.size() == 0) unexpected("b_done");
                else begin
                    b_dc = b_dq.pop_front();
                    chk("b_done_cycle", cyc, b_dc);
                end
            end
        end
        b_req_prev  <= b_req;
        b_done_prev <= b_done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Accept happens on the edge inside tick(); toggle expected TransportCycle edges later.
    task automatic send_a(input logic [7:0] d);
        tx_t e;
        a_valid = 1'b1;
        a_data  = d;
        chk("a_ready_pre", a_ready, 1);
        tick();
        e.data = d;
        e.cyc  = cyc + 2;
        a_txq.push_back(e);
        a_valid = 1'b0;
        chk("a_capture", a_dout, d);
    endtask

    task automatic send_b(input logic [7:0] d);
        tx_t e;
        b_valid = 1'b1;
        b_data  = d;
        chk("b_ready_pre", b_ready, 1);
        tick();
        e.data = d;
        e.cyc  = cyc;
        b_txq.push_back(e);
        b_valid = 1'b0;
        chk("b_capture", b_dout, d);
        chk("b_req_on_accept", b_req, b_req_prev ^ 1'b1);
    endtask

    // Ack sampled at the next edge, three sync flops, then one compare edge.
    task automatic ack_a;
        a_ack = ~a_ack;
        a_dq.push_back(cyc + 4);
    endtask

    task automatic ack_b;
        b_ack = ~b_ack;
        b_dq.push_back(cyc + 4);
    endtask

    initial begin
        // reset state
        ticks(3);
        rst = 1'b0;
        chk("a_rst_ready", a_ready, 1);
        chk("a_rst_req", a_req, 0);
        chk("a_rst_dout", a_dout, 0);
        chk("a_rst_done", a_done, 0);
        chk("a_rst_err", a_err, 0);
        chk("b_rst_ready", b_ready, 1);
        chk("b_rst_req", b_req, 0);
        chk("b_rst_dout", b_dout, 0);
        chk("b_rst_err", b_err, 0);

        // single transfer: accept at 10, toggle at 12, ack at 20, done at 24
        while (cyc < 9) tick();
        send_a(8'hA5);
        chk("a_req_setup10", a_req, 0);
        tick();
        chk("a_req_setup11", a_req, 0);
        chk("a_ready_setup", a_ready, 0);
        while (cyc < 20) tick();
        ack_a();
        while (cyc < 23) tick();
        chk("a_ready_23", a_ready, 0);
        tick();
        chk("a_ready_24", a_ready, 1);
        chk("a_done_24", a_done, 1);
        tick();
        chk("a_done_25", a_done, 0);

        // zero transport cycles on B
        send_b(8'h3C);
        tick();
        ack_b();
        ticks(6);
        chk("b_ready_after", b_ready, 1);

        // busy hold-off with back-to-back accept in the done cycle
        a_valid = 1'b1;
        a_data  = 8'h11;
        chk("a_ready_busy_pre", a_ready, 1);
        tick();
        begin
            tx_t e;
            e.data = 8'h11;
            e.cyc  = cyc + 2;
            a_txq.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            a_data = 8'h80 + 8'(i);
            chk("a_busy_ready", a_ready, 0);
            chk("a_busy_dout", a_dout, 8'h11);
            tick();
        end
        ack_a();
        for (int i = 0; i < 4; i++) begin
            chk("a_busy_ready2", a_ready, 0);
            chk("a_busy_dout2", a_dout, 8'h11);
            a_data = 8'hF0 + 8'(i);
            tick();
        end
        chk("a_ready_done_cycle", a_ready, 1);
        chk("a_done_cycle_hi", a_done, 1);
        a_data = 8'h22;
        tick();
        begin
            tx_t e;
            e.data = 8'h22;
            e.cyc  = cyc + 2;
            a_txq.push_back(e);
        end
        a_valid = 1'b0;
        chk("a_b2b_capture", a_dout, 8'h22);
        ticks(3);
        ack_a();
        ticks(6);

        // spurious ack glitch while idle
        a_ack = ~a_ack;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("a_spur_ready", a_ready, 1);
            chk("a_spur_req", a_req, 1);
            chk("a_spur_dout", a_dout, 8'h22);
        end
        a_ack = ~a_ack;
        ticks(6);
        send_a(8'h5A);
        ticks(4);
        chk("a_spur_wait", a_ready, 0);
        ack_a();
        ticks(6);
        chk("a_spur_ready_end", a_ready, 1);

        // reset while waiting for ack with req_out high
        send_a(8'hC3);
        ticks(4);
        chk("a_midrst_req_pre", a_req, 1);
        rst   = 1'b1;
        a_ack = 1'b0;
        b_ack = 1'b0;
        tick();
        rst = 1'b0;
        chk("a_midrst_req", a_req, 0);
        chk("a_midrst_dout", a_dout, 0);
        chk("a_midrst_ready", a_ready, 1);
        chk("a_midrst_done", a_done, 0);

        // timeout on B: no ack ever
        tick();
        send_b(8'hE7);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("b_to_err_pre", b_err, 0);
            chk("b_to_ready_pre", b_ready, 0);
        end
        b_valid = 1'b1;
        b_data  = 8'h99;
        tick();
        chk("b_to_err", b_err, TO_EN);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_to_err_hold", b_err, TO_EN);
            chk("b_to_ready", b_ready, 0);
            chk("b_to_req", b_req, 1);
            chk("b_to_dout", b_dout, 8'hE7);
        end
        b_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b_to_rst_err", b_err, 0);
        chk("b_to_rst_ready", b_ready, 1);

        ticks(5);
        chk("a_txq_empty", a_txq.size(), 0);
        chk("a_dq_empty", a_dq.size(), 0);
        chk("b_txq_empty", b_txq.size(), 0);
        chk("b_dq_empty", b_dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
